// File: rtl/inc_dec_pkg.sv
// Shared definitions for the up/down button input stage: FSM state encoding,
// default timing constants and a small elaboration-time helper.
package inc_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES     = 16;
   localparam int DEF_REPEAT_CYCLES   = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button path: 2-flop synchronizer, debouncer and IDLE/HOLD/REPEAT
// auto-repeat FSM producing single-cycle requests on press and while held.
module btn_channel
   import inc_dec_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_raw,
   input  logic i_repeat_en,
   output logic o_req
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int TMR_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] RPT_LAST   = TMR_W'(REPEAT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

   logic [1:0]       r_sync;
   logic [DEB_W-1:0] r_deb_cnt;
   logic             r_deb_state;
   logic [TMR_W-1:0] r_timer;
   btn_state_e       r_state;
   logic             r_req;
   logic             w_sync;

   assign w_sync = r_sync[1];
   assign o_req  = r_req;

   // Two-flop synchronizer for the asynchronous raw level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_btn_raw};
      end
   end

   // Debouncer: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_deb_cnt   <= '0;
         r_deb_state <= 1'b0;
      end else if (w_sync == r_deb_state) begin
         r_deb_cnt   <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
         r_deb_cnt   <= '0;
         r_deb_state <= w_sync;
      end else begin
         r_deb_cnt   <= r_deb_cnt + DEB_ONE;
      end
   end

   // Press/auto-repeat FSM; IDLE is only re-entered on release, so deb_state high there is a fresh press.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_req   <= 1'b0;
      end else begin
         r_req <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_deb_state) begin
                  r_req   <= 1'b1;
                  r_timer <= '0;
                  r_state <= ST_HOLD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (!r_deb_state) begin
                  r_state <= ST_IDLE;
               end else if (i_repeat_en) begin
                  if (r_timer == HOLD_LAST) begin
                     r_req   <= 1'b1;
                     r_timer <= '0;
                     r_state <= ST_REPEAT;
                  end else begin
                     r_timer <= r_timer + TMR_ONE;
                  end
               end else begin
                  r_timer <= r_timer;
               end
            end
            ST_REPEAT: begin
               if (!r_deb_state) begin
                  r_state <= ST_IDLE;
               end else if (i_repeat_en) begin
                  if (r_timer == RPT_LAST) begin
                     r_req   <= 1'b1;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer + TMR_ONE;
                  end
               end else begin
                  r_timer <= r_timer;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/inc_dec_button_ctrl.sv
// Up/down button front end: two debounced, auto-repeating channels whose
// requests are arbitrated into exclusive increment/decrement pulses.
module inc_dec_button_ctrl
   import inc_dec_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   input  logic repeat_en,
   output logic increment,
   output logic decrement,
   output logic conflict
);

   logic w_up_req;
   logic w_dn_req;
   logic r_increment;
   logic r_decrement;
   logic r_conflict;

   btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_up (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_btn_raw   (btn_up_raw),
      .i_repeat_en (repeat_en),
      .o_req       (w_up_req)
   );

   btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_dn (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_btn_raw   (btn_down_raw),
      .i_repeat_en (repeat_en),
      .o_req       (w_dn_req)
   );

   // Colliding requests are dropped and flagged, never queued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_increment <= 1'b0;
         r_decrement <= 1'b0;
         r_conflict  <= 1'b0;
      end else begin
         r_increment <= w_up_req & ~w_dn_req;
         r_decrement <= w_dn_req & ~w_up_req;
         r_conflict  <= w_up_req & w_dn_req;
      end
   end

   assign increment = r_increment;
   assign decrement = r_decrement;
   assign conflict  = r_conflict;

endmodule

// File: tb/tb_inc_dec_button_ctrl.sv
// Directed scoreboard bench for inc_dec_button_ctrl with default timing (4/16/8).
module tb_inc_dec_button_ctrl;

   typedef struct {
      int   cyc;
      logic inc;
      logic dec;
      logic con;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic btn_up_raw;
   logic btn_down_raw;
   logic repeat_en;
   logic increment;
   logic decrement;
   logic conflict;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;
   exp_t sb[$];

   inc_dec_button_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .btn_up_raw   (btn_up_raw),
      .btn_down_raw (btn_down_raw),
      .repeat_en    (repeat_en),
      .increment    (increment),
      .decrement    (decrement),
      .conflict     (conflict)
   );

   always #5 clk = ~clk;

   // cyc equals the number of the most recent rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic obs, input logic expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
      end
   endtask

   task automatic push(input int c, input logic i, input logic d, input logic k);
      exp_t e;
      e.cyc = c;
      e.inc = i;
      e.dec = d;
      e.con = k;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Every cycle: outputs must match the scoreboard entry for this edge, else all zero.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         e.cyc = cyc;
         e.inc = 1'b0;
         e.dec = 1'b0;
         e.con = 1'b0;
         if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
         chk("increment", increment, e.inc);
         chk("decrement", decrement, e.dec);
         chk("conflict", conflict, e.con);
      end
   end

   initial begin
      int k;
      int r;
      reset        = 1'b1;
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      repeat_en    = 1'b0;
      idle(3);
      chk("reset_inc", increment, 1'b0);
      chk("reset_dec", decrement, 1'b0);
      chk("reset_con", conflict, 1'b0);
      reset  = 1'b0;
      mon_en = 1'b1;
      idle(5);

      // tap: 12-cycle press gives one pulse at k+7
      btn_up_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b1, 1'b0, 1'b0);
      idle(12);
      btn_up_raw = 1'b0;
      idle(25);

      // 3-sample glitch is discarded
      btn_up_raw = 1'b1;
      idle(3);
      btn_up_raw = 1'b0;
      idle(25);

      // 4 samples is the shortest accepted press
      btn_down_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b0, 1'b1, 1'b0);
      idle(4);
      btn_down_raw = 1'b0;
      idle(25);

      // auto-repeat: t, t+16, then every 8 until the release reaches the FSM
      repeat_en  = 1'b1;
      btn_up_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) push(k + 23 + 8 * n, 1'b1, 1'b0, 1'b0);
      idle(60);
      btn_up_raw = 1'b0;
      idle(30);
      repeat_en = 1'b0;

      // simultaneous press collides
      btn_up_raw   = 1'b1;
      btn_down_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b0, 1'b0, 1'b1);
      idle(12);
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      idle(25);

      // adjacent presses both pass
      btn_up_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b1, 1'b0, 1'b0);
      idle(1);
      btn_down_raw = 1'b1;
      push(k + 8, 1'b0, 1'b1, 1'b0);
      idle(12);
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      idle(25);

      // long hold without repeat gives exactly one pulse
      btn_down_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b0, 1'b1, 1'b0);
      idle(40);
      btn_down_raw = 1'b0;
      idle(25);

      // reset while a repeat pulse is on the output
      repeat_en  = 1'b1;
      btn_up_raw = 1'b1;
      k = cyc + 1;
      push(k + 7, 1'b1, 1'b0, 1'b0);
      push(k + 23, 1'b1, 1'b0, 1'b0);
      push(k + 31, 1'b1, 1'b0, 1'b0);
      wait_cyc(k + 38);
      @(posedge clk);
      #1;
      chk("pre_reset_inc", increment, 1'b1);
      reset = 1'b1;
      #1;
      chk("async_reset_inc", increment, 1'b0);
      chk("async_reset_dec", decrement, 1'b0);
      chk("async_reset_con", conflict, 1'b0);
      idle(3);
      reset = 1'b0;
      r = cyc + 1;
      push(r + 7, 1'b1, 1'b0, 1'b0);
      push(r + 23, 1'b1, 1'b0, 1'b0);
      wait_cyc(r + 23);
      btn_up_raw = 1'b0;
      idle(30);
      repeat_en = 1'b0;

      chk("sb_empty", sb.size() == 0, 1'b1);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
